// File: rtl/cpu_core_ws.sv
// cpu_core_ws: multicycle accumulator CPU with a register file, Z/V flags,
// conditional jumps, a halt state and a wait-state memory handshake.
module cpu_core_ws #(
    parameter int unsigned INST_SIZE     = 6,
    parameter int unsigned REG_ADDR_SIZE = 4,
    parameter int unsigned MEM_ADDR_SIZE = 6,
    parameter int unsigned WORD_SIZE     = INST_SIZE + REG_ADDR_SIZE + MEM_ADDR_SIZE,
    parameter logic [MEM_ADDR_SIZE-1:0] RESET_PC = '0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     mem_ready,
    input  logic [WORD_SIZE-1:0]     mem_data_in,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [MEM_ADDR_SIZE-1:0] mem_address_bus,
    output logic [WORD_SIZE-1:0]     mem_data_out,
    output logic                     halted
);

    localparam int unsigned NUM_REGS = 1 << REG_ADDR_SIZE;
    localparam int unsigned MSB      = WORD_SIZE - 1;

    localparam logic [INST_SIZE-1:0] OP_LDA  = INST_SIZE'(1);
    localparam logic [INST_SIZE-1:0] OP_STA  = INST_SIZE'(2);
    localparam logic [INST_SIZE-1:0] OP_ADD  = INST_SIZE'(3);
    localparam logic [INST_SIZE-1:0] OP_SUB  = INST_SIZE'(4);
    localparam logic [INST_SIZE-1:0] OP_AND  = INST_SIZE'(5);
    localparam logic [INST_SIZE-1:0] OP_OR   = INST_SIZE'(6);
    localparam logic [INST_SIZE-1:0] OP_XOR  = INST_SIZE'(7);
    localparam logic [INST_SIZE-1:0] OP_JMP  = INST_SIZE'(8);
    localparam logic [INST_SIZE-1:0] OP_JZ   = INST_SIZE'(9);
    localparam logic [INST_SIZE-1:0] OP_JV   = INST_SIZE'(10);
    localparam logic [INST_SIZE-1:0] OP_MOVR = INST_SIZE'(11);
    localparam logic [INST_SIZE-1:0] OP_MOVA = INST_SIZE'(12);
    localparam logic [INST_SIZE-1:0] OP_ADDR = INST_SIZE'(13);
    localparam logic [INST_SIZE-1:0] OP_HLT  = {INST_SIZE{1'b1}};

    typedef enum logic [2:0] {
        S_START = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t                     r_state;
    state_t                     w_next_state;
    logic [MEM_ADDR_SIZE-1:0]   r_pc;
    logic [WORD_SIZE-1:0]       r_ir;
    logic [WORD_SIZE-1:0]       r_acc;
    logic                       r_z;
    logic                       r_v;
    logic [WORD_SIZE-1:0]       r_regs [NUM_REGS];

    logic [INST_SIZE-1:0]       w_opcode;
    logic [REG_ADDR_SIZE-1:0]   w_reg_sel;
    logic [MEM_ADDR_SIZE-1:0]   w_addr;
    logic                       w_is_mem_op;
    logic                       w_is_store;
    logic [WORD_SIZE-1:0]       w_operand;
    logic [WORD_SIZE-1:0]       w_sum;
    logic [WORD_SIZE-1:0]       w_diff;
    logic                       w_add_ovf;
    logic                       w_sub_ovf;
    logic [WORD_SIZE-1:0]       w_result;
    logic                       w_result_v;

    assign w_opcode    = r_ir[WORD_SIZE-1 -: INST_SIZE];
    assign w_reg_sel   = r_ir[MEM_ADDR_SIZE +: REG_ADDR_SIZE];
    assign w_addr      = r_ir[MEM_ADDR_SIZE-1:0];
    assign w_is_mem_op = (w_opcode >= OP_LDA) && (w_opcode <= OP_XOR);
    assign w_is_store  = (w_opcode == OP_STA);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_START;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; requests hold their state until mem_ready
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_START: w_next_state = S_FETCH;
            S_FETCH: if (mem_ready) w_next_state = S_EXEC;
            S_EXEC: begin
                if (w_opcode == OP_HLT)  w_next_state = S_HALT;
                else if (w_is_mem_op)    w_next_state = S_MEM;
                else                     w_next_state = S_FETCH;
            end
            S_MEM:   if (mem_ready) w_next_state = S_FETCH;
            S_HALT:  w_next_state = S_HALT;
            default: w_next_state = S_START;
        endcase
    end

    // Bus strobes and address decoded from the state register so reset drops them at once
    always_comb begin
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address_bus = '0;
        mem_data_out    = r_acc;
        halted          = (r_state == S_HALT);
        case (r_state)
            S_FETCH: begin
                mem_read        = 1'b1;
                mem_address_bus = r_pc;
            end
            S_MEM: begin
                mem_read        = !w_is_store;
                mem_write       = w_is_store;
                mem_address_bus = w_addr;
            end
            default: ;
        endcase
    end

    // ALU: memory operand in MEM, register operand in EXEC
    always_comb begin
        w_operand  = (r_state == S_MEM) ? mem_data_in : r_regs[w_reg_sel];
        w_sum      = r_acc + w_operand;
        w_diff     = r_acc - w_operand;
        w_add_ovf  = (r_acc[MSB] == w_operand[MSB]) && (w_sum[MSB] != r_acc[MSB]);
        w_sub_ovf  = (r_acc[MSB] != w_operand[MSB]) && (w_diff[MSB] != r_acc[MSB]);
        w_result   = r_acc;
        w_result_v = r_v;
        case (w_opcode)
            OP_LDA:  w_result = w_operand;
            OP_ADD: begin
                w_result   = w_sum;
                w_result_v = w_add_ovf;
            end
            OP_SUB: begin
                w_result   = w_diff;
                w_result_v = w_sub_ovf;
            end
            OP_AND:  w_result = r_acc & w_operand;
            OP_OR:   w_result = r_acc | w_operand;
            OP_XOR:  w_result = r_acc ^ w_operand;
            OP_MOVA: w_result = w_operand;
            OP_ADDR: begin
                w_result   = w_sum;
                w_result_v = w_add_ovf;
            end
            default: ;
        endcase
    end

    // Datapath: PC, IR, ACC, flags and register file
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc  <= RESET_PC;
            r_ir  <= '0;
            r_acc <= '0;
            r_z   <= 1'b0;
            r_v   <= 1'b0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (mem_ready) begin
                        r_ir <= mem_data_in;
                        r_pc <= r_pc + MEM_ADDR_SIZE'(1);
                    end
                end
                S_EXEC: begin
                    case (w_opcode)
                        OP_JMP:  r_pc <= w_addr;
                        OP_JZ:   if (r_z) r_pc <= w_addr;
                        OP_JV:   if (r_v) r_pc <= w_addr;
                        OP_MOVR: r_regs[w_reg_sel] <= r_acc;
                        OP_MOVA, OP_ADDR: begin
                            r_acc <= w_result;
                            r_z   <= (w_result == '0);
                            r_v   <= w_result_v;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready && !w_is_store) begin
                        r_acc <= w_result;
                        r_z   <= (w_result == '0);
                        r_v   <= w_result_v;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_core_ws.sv
// tb_cpu_core_ws: table vectors, directed multi-cycle sequences and random
// programs checked against an instruction-level model of the core.
module tb_cpu_core_ws;

    localparam int unsigned WS    = 16;
    localparam int unsigned AS    = 6;
    localparam int unsigned DEPTH = 64;

    logic          clock = 1'b0;
    logic          reset;
    logic          mem_ready;
    logic [WS-1:0] mem_data_in;
    logic          mem_read;
    logic          mem_write;
    logic [AS-1:0] mem_address_bus;
    logic [WS-1:0] mem_data_out;
    logic          halted;

    cpu_core_ws dut (
        .clock           (clock),
        .reset           (reset),
        .mem_ready       (mem_ready),
        .mem_data_in     (mem_data_in),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address_bus (mem_address_bus),
        .mem_data_out    (mem_data_out),
        .halted          (halted)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic          wr;
        logic [AS-1:0] addr;
        logic [WS-1:0] data;
    } xact_t;

    typedef struct {
        int          op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        bit          z;
        bit          v;
    } vec_t;

    xact_t       exp_q[$];
    xact_t       act_q[$];
    logic [WS-1:0] mem   [DEPTH];
    logic [WS-1:0] m_mem [DEPTH];
    vec_t        tbl [12];

    int  n_vec = 0;
    int  n_bad = 0;
    int  cyc, halt_cyc, first_req_cyc, wait_fixed, need, cnt;
    bit  stall, pending, rdy;
    logic [23:0] saved_req;
    bit  model_halt;
    int  model_cyc, model_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string why);
        n_vec++;
        n_bad++;
        $display("FAIL %s: %s", name, why);
    endtask

    function automatic logic [15:0] enc(input int op, input int rg, input int ad);
        return {6'(op), 4'(rg), 6'(ad)};
    endfunction

    function automatic xact_t mk(input bit wr, input int addr, input logic [15:0] data);
        xact_t x;
        x.wr   = wr;
        x.addr = 6'(addr);
        x.data = data;
        return x;
    endfunction

    // Two's complement add/sub via plain integers; bit 16 is signed overflow
    function automatic logic [16:0] arith(input logic [15:0] a, input logic [15:0] b, input bit sub);
        int sa, sb, r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = sub ? sa - sb : sa + sb;
        return {(r > 32767) || (r < -32768), r[15:0]};
    endfunction

    function automatic bit fetched(input int a);
        foreach (act_q[i]) begin
            if (!act_q[i].wr && act_q[i].addr == 6'(a)) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Memory responder and bus monitor, acting mid-cycle
    always @(negedge clock) begin
        if (reset !== 1'b1) begin
            pending   = 1'b0;
            mem_ready = 1'b0;
        end else begin
            cyc++;
            if (pending) begin
                chk("req_stable", 32'({mem_read, mem_write, mem_address_bus, mem_data_out}), 32'(saved_req));
            end
            if (mem_read || mem_write) begin
                chk("strobe_excl", 32'(mem_read & mem_write), 32'(0));
                if (!pending) begin
                    need = (wait_fixed >= 0) ? wait_fixed : int'($urandom_range(0, 2));
                    cnt  = 0;
                    if (first_req_cyc < 0) first_req_cyc = cyc;
                end
                rdy = !stall && (cnt >= need);
                cnt++;
                mem_ready   = rdy;
                mem_data_in = mem[mem_address_bus];
                if (rdy) begin
                    act_q.push_back(mk(mem_write, int'(mem_address_bus), mem_write ? mem_data_out : 16'h0));
                    if (mem_write) mem[mem_address_bus] = mem_data_out;
                end
                pending   = !rdy;
                saved_req = {mem_read, mem_write, mem_address_bus, mem_data_out};
            end else begin
                pending     = 1'b0;
                mem_ready   = 1'($urandom);
                mem_data_in = 16'($urandom);
            end
            if (halted && halt_cyc < 0) halt_cyc = cyc;
        end
    end

    // Instruction-level model: expected bus trace, cycle count and access count
    task automatic run_model(input int max_instr);
        logic [15:0] acc, ir, opnd;
        logic [16:0] r;
        logic [15:0] regs [16];
        bit z, v;
        int pc, op, rg, ad;
        acc = '0; z = 1'b0; v = 1'b0; pc = 0;
        model_halt = 1'b0; model_cyc = 1; model_acc = 0;
        foreach (regs[i]) regs[i] = '0;
        exp_q.delete();
        for (int n = 0; n < max_instr && !model_halt; n++) begin
            exp_q.push_back(mk(1'b0, pc, 16'h0));
            model_acc++;
            ir = m_mem[pc];
            pc = (pc + 1) % 64;
            op = int'(ir[15:10]);
            rg = int'(ir[9:6]);
            ad = int'(ir[5:0]);
            if (op == 63) begin
                model_cyc += 2;
                model_halt = 1'b1;
            end else if (op >= 1 && op <= 7) begin
                model_cyc += 3;
                model_acc++;
                if (op == 2) begin
                    exp_q.push_back(mk(1'b1, ad, acc));
                    m_mem[ad] = acc;
                end else begin
                    exp_q.push_back(mk(1'b0, ad, 16'h0));
                    opnd = m_mem[ad];
                    case (op)
                        1: acc = opnd;
                        3: begin r = arith(acc, opnd, 1'b0); acc = r[15:0]; v = r[16]; end
                        4: begin r = arith(acc, opnd, 1'b1); acc = r[15:0]; v = r[16]; end
                        5: acc = acc & opnd;
                        6: acc = acc | opnd;
                        default: acc = acc ^ opnd;
                    endcase
                    z = (acc == 16'h0);
                end
            end else begin
                model_cyc += 2;
                case (op)
                    8:  pc = ad;
                    9:  if (z) pc = ad;
                    10: if (v) pc = ad;
                    11: regs[rg] = acc;
                    12: begin acc = regs[rg]; z = (acc == 16'h0); end
                    13: begin r = arith(acc, regs[rg], 1'b0); acc = r[15:0]; v = r[16]; z = (acc == 16'h0); end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic reset_on();
        @(negedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic release_rst(input int wmode);
        @(negedge clock);
        #1;
        act_q.delete();
        cyc           = 0;
        halt_cyc      = -1;
        first_req_cyc = -1;
        wait_fixed    = wmode;
        reset         = 1'b1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) begin
            mem[i]   = '0;
            m_mem[i] = '0;
        end
    endtask

    task automatic put(input int a, input logic [15:0] w);
        mem[a]   = w;
        m_mem[a] = w;
    endtask

    task automatic run_dut(input string name, input int budget);
        int n = 0;
        int sz;
        while (!(model_halt ? (halt_cyc >= 0) : (act_q.size() >= exp_q.size())) && n < budget) begin
            @(negedge clock);
            #2;
            n++;
        end
        if (n >= budget) fail({name, "_timeout"}, "no completion within cycle budget");
        if (model_halt) begin
            sz = act_q.size();
            repeat (5) begin
                @(negedge clock);
                #2;
            end
            chk({name, "_quiet"}, 32'(act_q.size()), 32'(sz));
            chk({name, "_halted"}, 32'(halted), 32'(1));
            if (wait_fixed >= 0)
                chk({name, "_cycles"}, 32'(halt_cyc), 32'(model_cyc + wait_fixed * model_acc));
        end
        foreach (exp_q[i]) begin
            if (i >= act_q.size()) begin
                fail($sformatf("%s_x%0d", name, i), "bus transaction missing");
                break;
            end
            chk($sformatf("%s_x%0d", name, i), 32'(act_q[i]), 32'(exp_q[i]));
        end
        if (model_halt) chk({name, "_len"}, 32'(act_q.size()), 32'(exp_q.size()));
    endtask

    task automatic run_prog(input string name, input int wmode, input int max_instr, input int budget);
        run_model(max_instr);
        release_rst(wmode);
        run_dut(name, budget);
    endtask

    task automatic load_prog1();
        clear_mem();
        put(0, enc(1, 0, 10));
        put(1, enc(3, 0, 11));
        put(2, enc(2, 0, 12));
        put(3, enc(63, 0, 0));
        put(10, 16'd5);
        put(11, 16'd7);
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; wait_fixed = 0;
        mem_ready = 1'b0; mem_data_in = '0;
        halt_cyc = -1; first_req_cyc = -1; cyc = 0;

        //          op  a         b         res       z     v
        tbl[0]  = '{3,  16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
        tbl[1]  = '{3,  16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
        tbl[2]  = '{3,  16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
        tbl[3]  = '{4,  16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0};
        tbl[4]  = '{4,  16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1};
        tbl[5]  = '{4,  16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0};
        tbl[6]  = '{5,  16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0};
        tbl[7]  = '{5,  16'hF0F0, 16'h0F0F, 16'h0000, 1'b1, 1'b0};
        tbl[8]  = '{6,  16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0};
        tbl[9]  = '{7,  16'h1234, 16'hFFFF, 16'hEDCB, 1'b0, 1'b0};
        tbl[10] = '{1,  16'h0005, 16'h0000, 16'h0000, 1'b1, 1'b0};
        tbl[11] = '{14, 16'h1234, 16'h5555, 16'h1234, 1'b0, 1'b0};

        // Reset in the middle of a stalled fetch
        reset_on();
        load_prog1();
        stall = 1'b1;
        release_rst(0);
        repeat (3) begin
            @(negedge clock);
            #2;
        end
        chk("rst_fetch_pending", 32'(mem_read), 32'(1));
        reset = 1'b0;
        #1;
        chk("rst_read_drop", 32'(mem_read), 32'(0));
        chk("rst_outputs", 32'({mem_read, mem_write, mem_address_bus, mem_data_out, halted}), 32'(0));
        stall = 1'b0;
        run_model(20);
        release_rst(0);
        #1;
        chk("start_outputs", 32'({mem_read, mem_write, mem_address_bus, mem_data_out, halted}), 32'(0));
        run_dut("rst_prog", 200);
        chk("rst_first_fetch_cyc", 32'(first_req_cyc), 32'(1));

        // LDA/ADD/STA/HLT with zero and two wait states
        reset_on();
        load_prog1();
        run_prog("prog1_w0", 0, 20, 200);
        chk("prog1_w0_halt_cyc", 32'(halt_cyc), 32'(12));
        chk("prog1_w0_m12", 32'(mem[12]), 32'(12));
        chk("prog1_w0_z", 32'(dut.r_z), 32'(0));
        chk("prog1_w0_v", 32'(dut.r_v), 32'(0));
        reset_on();
        load_prog1();
        run_prog("prog1_w2", 2, 20, 200);
        chk("prog1_w2_halt_cyc", 32'(halt_cyc), 32'(26));
        chk("prog1_w2_m12", 32'(mem[12]), 32'(12));

        // Overflow then JV taken; SUB to zero then JZ taken
        reset_on();
        clear_mem();
        put(0, enc(1, 0, 30));  put(1, enc(3, 0, 31));  put(2, enc(10, 0, 20)); put(3, enc(63, 0, 0));
        put(20, enc(2, 0, 32)); put(21, enc(4, 0, 32)); put(22, enc(9, 0, 25));  put(23, enc(63, 0, 0));
        put(25, enc(2, 0, 33)); put(26, enc(63, 0, 0));
        put(30, 16'h7FFF); put(31, 16'h0001); put(33, 16'hDEAD);
        run_prog("flags", 1, 30, 300);
        chk("flags_m32", 32'(mem[32]), 32'h8000);
        chk("flags_m33", 32'(mem[33]), 32'h0000);
        chk("flags_jv_target", act_q.size() > 5 ? 32'(act_q[5].addr) : 32'hFFFF_FFFF, 32'd20);
        chk("flags_jz_target", act_q.size() > 10 ? 32'(act_q[10].addr) : 32'hFFFF_FFFF, 32'd25);

        // Register file round trip and undefined opcode
        reset_on();
        clear_mem();
        put(0, enc(1, 0, 40));  put(1, enc(11, 3, 0)); put(2, enc(1, 0, 41));
        put(3, enc(12, 3, 0));  put(4, enc(2, 0, 42)); put(5, enc(13, 3, 0));
        put(6, enc(2, 0, 43));  put(7, enc(14, 0, 0)); put(8, enc(63, 0, 0));
        put(40, 16'h0123); put(41, 16'h0000);
        run_prog("regs", 0, 30, 300);
        chk("regs_mova", 32'(mem[42]), 32'h0123);
        chk("regs_addr", 32'(mem[43]), 32'h0246);
        chk("regs_halt_cyc", 32'(halt_cyc), 32'd23);

        // PC wrap from 63 to 0 (self-modified HLT at 0)
        reset_on();
        clear_mem();
        put(0, enc(8, 0, 60)); put(60, enc(1, 0, 50)); put(61, enc(2, 0, 0));
        put(50, enc(63, 0, 0));
        run_prog("wrap", 0, 20, 200);
        chk("wrap_addr", act_q.size() > 7 ? 32'(act_q[7].addr) : 32'hFFFF_FFFF, 32'd0);

        // Table of single-ALU-op vectors; Z and V observed through JZ/JV
        for (int k = 0; k < 12; k++) begin
            reset_on();
            clear_mem();
            put(0, enc(1, 0, 40)); put(1, enc(tbl[k].op, 0, 41)); put(2, enc(2, 0, 42));
            put(3, enc(9, 0, 5));  put(5, enc(10, 0, 7));         put(7, enc(63, 0, 0));
            put(40, tbl[k].a); put(41, tbl[k].b);
            run_prog($sformatf("tbl%0d", k), k % 3, 30, 400);
            chk($sformatf("tbl%0d_res", k), 32'(mem[42]), 32'(tbl[k].res));
            chk($sformatf("tbl%0d_z", k), 32'(!fetched(4)), 32'(tbl[k].z));
            chk($sformatf("tbl%0d_v", k), 32'(!fetched(6)), 32'(tbl[k].v));
        end

        // Random programs with random or fixed wait states
        for (int t = 0; t < 25; t++) begin
            int r, op;
            reset_on();
            clear_mem();
            for (int i = 0; i < 64; i++) begin
                r  = int'($urandom_range(0, 99));
                op = (r < 4) ? 63 : (r < 88) ? int'($urandom_range(0, 13)) : int'($urandom_range(14, 62));
                if (i >= 56) put(i, 16'($urandom));
                else         put(i, enc(op, int'($urandom_range(0, 15)), int'($urandom_range(0, 63))));
            end
            run_prog($sformatf("rnd%0d", t), int'($urandom_range(0, 3)) - 1, 60, 1500);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
